wb_write_queue: RTL and testbench



---
 rtl/wb_write_queue_if.sv | 45 ++++
 rtl/wb_write_queue.sv | 93 +++++++++
 tb/tb_wb_write_queue.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_write_queue_if.sv
// ------------------------------------------------------------------
// wb_write_queue_if: pipe/secondary/register-file/decode bundle of wb_write_queue.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface wb_write_queue_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
);
  logic                   pipe_we;
  logic [AW-1:0]          pipe_waddr;
  logic [DW-1:0]          pipe_wdata;
  logic                   sec_valid;
  logic                   sec_ready;
  logic [AW-1:0]          sec_waddr;
  logic [DW-1:0]          sec_wdata;
  logic                   rf_we;
  logic [AW-1:0]          rf_waddr;
  logic [DW-1:0]          rf_wdata;
  logic [AW-1:0]          q_addr_a;
  logic [AW-1:0]          q_addr_b;
  logic                   pend_a;
  logic                   pend_b;
  logic [$clog2(DEPTH):0] q_count;

  modport master (
    output pipe_we, pipe_waddr, pipe_wdata,
    output sec_valid, sec_waddr, sec_wdata,
    output q_addr_a, q_addr_b,
    input  sec_ready, rf_we, rf_waddr, rf_wdata,
    input  pend_a, pend_b, q_count
  );

  modport slave (
    input  pipe_we, pipe_waddr, pipe_wdata,
    input  sec_valid, sec_waddr, sec_wdata,
    input  q_addr_a, q_addr_b,
    output sec_ready, rf_we, rf_waddr, rf_wdata,
    output pend_a, pend_b, q_count
  );
endinterface

`default_nettype wire

// File: rtl/wb_write_queue.sv
// ------------------------------------------------------------------
// wb_write_queue: register-file write-port arbiter, WB first, secondary results via FIFO.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module wb_write_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  wb_write_queue_if.slave      bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0] live;
  logic [AW-1:0]    addr_mem [DEPTH];
  logic [DW-1:0]    data_mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;

  logic pipe_wr;
  logic pop;
  logic enq;
  logic hit_a;
  logic hit_b;

  assign pipe_wr       = bus.pipe_we && (bus.pipe_waddr != '0);
  assign pop           = !reset && !pipe_wr && (count != '0);
  assign bus.sec_ready = !reset && (count < CW'(DEPTH));
  assign enq           = bus.sec_valid && bus.sec_ready;
  assign bus.q_count   = count;

  // Live is cleared on pop, so a set live bit always marks an occupied entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      live  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (pipe_wr && (addr_mem[i] == bus.pipe_waddr)) begin
          live[i] <= 1'b0;
        end
      end
      if (pop) begin
        live[head] <= 1'b0;
        head       <= head + 1'b1;
      end
      // Enqueue comes last so the younger entry survives a same-cycle kill.
      if (enq) begin
        live[tail]     <= (bus.sec_waddr != '0);
        addr_mem[tail] <= bus.sec_waddr;
        data_mem[tail] <= bus.sec_wdata;
        tail           <= tail + 1'b1;
      end
      count <= count + CW'(enq) - CW'(pop);
    end
  end

  always_comb begin
    bus.rf_we    = 1'b0;
    bus.rf_waddr = '0;
    bus.rf_wdata = '0;
    if (pipe_wr && !reset) begin
      bus.rf_we    = 1'b1;
      bus.rf_waddr = bus.pipe_waddr;
      bus.rf_wdata = bus.pipe_wdata;
    end else if (pop && live[head]) begin
      bus.rf_we    = 1'b1;
      bus.rf_waddr = addr_mem[head];
      bus.rf_wdata = data_mem[head];
    end
  end

  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live[i] && (addr_mem[i] == bus.q_addr_a)) hit_a = 1'b1;
      if (live[i] && (addr_mem[i] == bus.q_addr_b)) hit_b = 1'b1;
    end
    bus.pend_a = hit_a && !reset && (bus.q_addr_a != '0);
    bus.pend_b = hit_b && !reset && (bus.q_addr_b != '0);
  end
endmodule

`default_nettype wire

// File: tb/tb_wb_write_queue.sv
// ------------------------------------------------------------------
// tb_wb_write_queue: directed and random checks of wb_write_queue against a queue model.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_wb_write_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  typedef struct packed {
    logic          live;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fails  = 0;

  ent_t          mq[$];
  logic [DW-1:0] model_rf [32];
  logic [DW-1:0] obs_rf   [32];

  wb_write_queue_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

  wb_write_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic pwe, input int paddr, input logic [DW-1:0] pdata,
                       input logic sv, input int saddr, input logic [DW-1:0] sdata,
                       input int qa, input int qb);
    bus.pipe_we    = pwe;
    bus.pipe_waddr = AW'(paddr);
    bus.pipe_wdata = pdata;
    bus.sec_valid  = sv;
    bus.sec_waddr  = AW'(saddr);
    bus.sec_wdata  = sdata;
    bus.q_addr_a   = AW'(qa);
    bus.q_addr_b   = AW'(qb);
  endtask

  // Check combinational outputs against the model, then advance one clock.
  task automatic tick();
    logic          pipe_wr;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic          e_pa;
    logic          e_pb;
    logic          check_bus;
    logic          enq;
    ent_t          e;
    #1;
    pipe_wr   = bus.pipe_we && bus.pipe_waddr != 0;
    e_we      = 1'b0;
    e_addr    = '0;
    e_data    = '0;
    check_bus = 1'b1;
    e_pa      = 1'b0;
    e_pb      = 1'b0;
    if (!reset) begin
      if (pipe_wr) begin
        e_we = 1'b1; e_addr = bus.pipe_waddr; e_data = bus.pipe_wdata;
      end else if (mq.size() > 0) begin
        if (mq[0].live) begin
          e_we = 1'b1; e_addr = mq[0].addr; e_data = mq[0].data;
        end else begin
          check_bus = 1'b0;
        end
      end
      foreach (mq[i]) begin
        if (mq[i].live && mq[i].addr == bus.q_addr_a && bus.q_addr_a != 0) e_pa = 1'b1;
        if (mq[i].live && mq[i].addr == bus.q_addr_b && bus.q_addr_b != 0) e_pb = 1'b1;
      end
      check("q_count", 64'(bus.q_count), 64'(mq.size()));
    end
    check("rf_we", 64'(bus.rf_we), 64'(e_we));
    if (check_bus) begin
      check("rf_waddr", 64'(bus.rf_waddr), 64'(e_addr));
      check("rf_wdata", 64'(bus.rf_wdata), 64'(e_data));
    end
    check("sec_ready", 64'(bus.sec_ready), 64'(!reset && mq.size() < DEPTH));
    check("pend_a", 64'(bus.pend_a), 64'(e_pa));
    check("pend_b", 64'(bus.pend_b), 64'(e_pb));
    check("rf_we_r0", 64'(bus.rf_we === 1'b1 && bus.rf_waddr == 0), 64'(0));
    if (bus.rf_we === 1'b1) obs_rf[bus.rf_waddr] = bus.rf_wdata;

    @(posedge clk);
    if (reset) begin
      mq.delete();
    end else begin
      enq = bus.sec_valid && mq.size() < DEPTH;
      if (pipe_wr) begin
        foreach (mq[i]) if (mq[i].addr == bus.pipe_waddr) mq[i].live = 1'b0;
        model_rf[bus.pipe_waddr] = bus.pipe_wdata;
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        if (e.live) model_rf[e.addr] = e.data;
      end
      if (enq) mq.push_back('{live: bus.sec_waddr != 0, addr: bus.sec_waddr, data: bus.sec_wdata});
    end
    @(negedge clk);
  endtask

  initial begin
    foreach (model_rf[i]) begin
      model_rf[i] = '0;
      obs_rf[i]   = '0;
    end
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Single enqueue with idle pipe, written the next cycle
    drive(0, 0, 0, 1, 5, 32'hAAAA0005, 5, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 5, 0);
    tick();
    tick();

    // Fill while the pipe owns the port, then drain in order
    for (int i = 1; i <= 4; i++) begin
      drive(1, 8, 32'h800 + i, 1, i, 32'h100 + i, i, 3);
      tick();
    end
    drive(1, 8, 32'h8FF, 1, 6, 32'h666, 1, 4);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 0, 0, 2, 4);
      tick();
    end

    // Stale kill of a queued r7 by a younger pipe write
    drive(1, 8, 32'h1, 1, 7, 32'h11, 7, 0);
    tick();
    drive(1, 7, 32'h22, 0, 0, 0, 7, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 7, 7);
    tick();
    tick();
    check("r7_final", 64'(obs_rf[7]), 64'h22);

    // Same-cycle pipe write and enqueue to r9: the queued entry survives
    drive(1, 9, 32'h99, 1, 9, 32'h33, 9, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 9, 0);
    tick();
    tick();
    check("r9_final", 64'(obs_rf[9]), 64'h33);

    // r0 on both sources never writes
    drive(1, 0, 32'hDEAD, 1, 0, 32'hBEEF, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();

    // Reset mid-drain discards queued entries
    for (int i = 0; i < 4; i++) begin
      drive(1, 12, 32'hC0, 1, 20 + i, 32'h2000 + i, 20, 21);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 20, 21);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    tick();

    // Random traffic over a small register range to provoke conflicts
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 79) == 0);
      drive($urandom_range(0, 1), $urandom_range(0, 7), $urandom,
            $urandom_range(0, 2) != 0, $urandom_range(0, 7), $urandom,
            $urandom_range(0, 7), $urandom_range(0, 7));
      tick();
    end
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < DEPTH + 1; n++) tick();
    for (int r = 0; r < 32; r++) check($sformatf("rf_r%0d", r), 64'(obs_rf[r]), 64'(model_rf[r]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

`default_nettype wire
